// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int CODE_W   = 4;
  localparam int CNT_W    = 8;

  // Key code is the row in the upper two bits, column in the lower two.
  function automatic logic [CODE_W-1:0] rc_to_code(input logic [1:0] row,
                                                   input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous, active-low row inputs.
module keypad_sync
  import keypad_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] d,
  output logic [NUM_ROWS-1:0] q
);

  logic [NUM_ROWS-1:0] meta_p0;
  logic [NUM_ROWS-1:0] sync_p1;

  // Resetting to all-ones keeps the scanner from seeing a phantom press out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/io_keypad.sv
// 4x4 keypad scanner: column strobe, debounce, hex encode, valid/ready
// handshake, sticky overflow and an eight-digit history register.
// Optional build macro KEYPAD_AUTOREPEAT_EN adds typematic repeat while held.
module io_keypad
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [3:0]        row_n,
  output logic [3:0]        col_n,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_held,
  output logic              overflow,
  output logic [31:0]       digits
);

  localparam logic [CNT_W-1:0] DB_TICKS = CNT_W'(DEBOUNCE_TICKS);

  if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 255 || REPEAT_DELAY < 1 || REPEAT_RATE < 1)
  begin : g_bad_param
    $error("io_keypad: parameter out of legal range");
  end

  logic [3:0]        rs;
  state_t            state;
  logic [1:0]        col;
  logic [1:0]        row_q;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  rcnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  rcnt_inc;
  logic              any_low;
  logic              key_down;
  logic [1:0]        low_row;
  logic [1:0]        emit_row;
  logic [CODE_W-1:0] emit_code;
  logic              emit;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [15:0]       rep;
  logic [15:0]       rep_inc;
  logic              rep_first;
  logic              rep_hit;
`endif

  keypad_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_n),
    .q   (rs)
  );

  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  assign col_n = ~(4'b0001 << col);

  // Decide whether this edge produces a key code, and which one.
  always_comb begin
    any_low  = (rs != 4'hF);
    low_row  = lowest_low(rs);
    key_down = ~rs[row_q];
    cnt_inc  = cnt + 1'b1;
    rcnt_inc = rcnt + 1'b1;
    emit_row = row_q;
    emit     = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_inc  = rep + 16'd1;
    rep_hit  = key_down && (rep_first ? (rep_inc == 16'(REPEAT_DELAY))
                                      : (rep_inc == 16'(REPEAT_RATE)));
`endif
    if (tick) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            emit_row = low_row;
            emit     = (DB_TICKS == 8'd1);
          end
        end
        DEBOUNCE: emit = key_down && (cnt_inc >= DB_TICKS);
`ifdef KEYPAD_AUTOREPEAT_EN
        HELD:     emit = rep_hit;
`endif
        default:  emit = 1'b0;
      endcase
    end
    emit_code = rc_to_code(emit_row, col);
  end

  // Scan/debounce FSM with handshake, overflow and digit history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      col       <= 2'd0;
      row_q     <= 2'd0;
      cnt       <= '0;
      rcnt      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      overflow  <= 1'b0;
      digits    <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep       <= '0;
      rep_first <= 1'b1;
`endif
    end else begin
      if (key_valid && key_ready)
        key_valid <= 1'b0;
      if (emit) begin
        digits <= {digits[27:0], emit_code};
        if (!key_valid || key_ready) begin
          key_code  <= emit_code;
          key_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
      if (tick) begin
        case (state)
          SCAN: begin
            if (!any_low) begin
              col <= col + 2'd1;
            end else begin
              row_q <= low_row;
              cnt   <= 8'd1;
              if (DB_TICKS == 8'd1) begin
                key_held <= 1'b1;
                rcnt     <= '0;
                state    <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep       <= '0;
                rep_first <= 1'b1;
`endif
              end else begin
                state <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (key_down) begin
              if (cnt_inc >= DB_TICKS) begin
                key_held <= 1'b1;
                rcnt     <= '0;
                state    <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep       <= '0;
                rep_first <= 1'b1;
`endif
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              // Full release or a different row: treat as noise and move on.
              col   <= col + 2'd1;
              state <= SCAN;
            end
          end
          HELD: begin
            if (!any_low) begin
              if (rcnt_inc >= DB_TICKS) begin
                key_held <= 1'b0;
                rcnt     <= '0;
                col      <= col + 2'd1;
                state    <= SCAN;
              end else begin
                rcnt <= rcnt_inc;
              end
            end else begin
              rcnt <= '0;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            if (key_down) begin
              if (rep_hit) begin
                rep       <= '0;
                rep_first <= 1'b0;
              end else begin
                rep <= rep_inc;
              end
            end else begin
              rep <= '0;
            end
`endif
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: doc/io_keypad.md
Name: io_keypad

Overview:
- Input-side companion to the 7-segment output path: scans a 4x4 active-low key matrix, debounces, encodes each press to a 4-bit hex code.
- Presents each code to the CPU/bus side through a valid/ready handshake.
- Shifts each code into a 32-bit digit register laid out for direct feed to the display data word.
- Column strobing is paced by an external scan tick, as the display scan is.

Parameters:
- DEBOUNCE_TICKS, 4, consecutive stable ticks required to accept a press or a release (legal range 1..255).
- REPEAT_DELAY, 32, ticks from press acceptance to first auto-repeat (only with KEYPAD_AUTOREPEAT_EN).
- REPEAT_RATE, 8, ticks between subsequent auto-repeats (only with KEYPAD_AUTOREPEAT_EN).

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  one-clk scan strobe; all scan, debounce and repeat timing advances only on clk edges with tick=1.
- row_n  input  4  matrix rows, active low, asynchronous to clk.
- col_n  output  4  column drive, active low, exactly one bit low at all times.
- key_code  output  4  code of the pending key, code = row*4 + col.
- key_valid  output  1  pending key available.
- key_ready  input  1  consumer accepts; transfer occurs on a clk edge with key_valid & key_ready.
- key_held  output  1  a debounced key is currently down.
- overflow  output  1  sticky; a key was dropped while key_valid was high.
- digits  output  32  last eight codes, newest in [3:0].

Behaviour:
- row_n passes a 2-flop synchronizer; FSM logic uses only the synchronized value rs.
- Reset values: col_n=4'b1110, key_code=0, key_valid=0, key_held=0, overflow=0, digits=0, FSM=SCAN, column index=0, all counters 0.
- SCAN, on tick:
  - rs==4'hF: rotate to the next column (3 wraps to 0); col_n updates the same edge.
  - Otherwise: capture row = lowest index with a low bit, keep the column, cnt=1, go DEBOUNCE.
  - The column is therefore driven for one full tick period before it is sampled.
- DEBOUNCE, on tick:
  - rs has the captured row low: cnt++.
  - rs==4'hF: return to SCAN and advance the column.
  - Captured row released but another row low: treat as noise; return to SCAN and advance the column.
  - cnt reaching DEBOUNCE_TICKS, or DEBOUNCE_TICKS=1 on entry: emit the key, key_held=1, go HELD.
- Emit:
  - If key_valid=0, or key_valid & key_ready on the same edge: key_code<=code, key_valid<=1.
  - Otherwise: drop the key, overflow<=1.
  - digits<={digits[27:0],code} on every emit, including dropped ones.
- HELD, on tick:
  - rs==4'hF: rcnt++; any low bit resets rcnt=0.
  - rcnt reaching DEBOUNCE_TICKS: key_held=0, advance the column, go SCAN.
  - Other keys pressed while held are ignored (no rollover).
- Handshake:
  - key_valid stays high with key_code stable until a transfer; on transfer key_valid<=0 unless a simultaneous emit reloads it.
  - overflow clears only on rst.
- rst during any state forces the reset values on that edge; a key held through reset is re-detected as a fresh press.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - In HELD, a repeat counter counts ticks while the key stays down.
  - Re-emits the same code after REPEAT_DELAY ticks, then every REPEAT_RATE ticks.
  - Emit rules above apply to each repeat (overflow, digits shift).
  - The counter clears on entering HELD and on the first tick of release debounce.
- Undefined: no repeat logic; exactly one emit per press; REPEAT_DELAY and REPEAT_RATE are unused.

Decomposition:
- Package keypad_pkg:
  - State enum {SCAN, DEBOUNCE, HELD}.
  - NUM_ROWS=4, NUM_COLS=4, CODE_W=4.
  - Debounce counter width 8.
  - Function for row/col to code.
- One sub-module: keypad_sync, a 4-bit 2-flop synchronizer for row_n.

Test Plan:
- Reset with rst high 2 clks -> col_n=4'b1110, key_valid=0, key_held=0, overflow=0, digits=0; no press -> col_n cycles 1110,1101,1011,0111,1110 on successive ticks.
- Press row 2 / col 1 stable with key_ready=0 -> key_valid=1, key_code=4'h9, key_held=1, digits=32'h9; key_ready=1 one clk -> key_valid=0 next edge.
- Row 2 / col 1 bouncing low for 2 ticks then high, DEBOUNCE_TICKS=4 -> no emit; scan resumes at column 2.
- Press 4'h5 and do not accept it; release; press 4'hA -> key_code stays 4'h5, overflow=1, digits=32'h5A.
- rst asserted mid-DEBOUNCE with the key held -> reset values next edge; key re-detected, emitted once.
- KEYPAD_AUTOREPEAT_EN defined, key 4'h3 held 32+2*8 ticks, key_ready=1 -> 3 emits of 4'h3, digits=32'h333; undefined -> exactly 1 emit.
